// File: rtl/ysyx_22040759_axi_mem_slave.sv
// AXI4 responder over an on-chip word memory: independent read and write
// burst engines share one array; full-width beats, FIXED/INCR bursts only.
module ysyx_22040759_axi_mem_slave #(
   parameter int AXI_ADDR_WIDTH = 64,
   parameter int AXI_DATA_WIDTH = 64,
   parameter int AXI_ID_WIDTH   = 4,
   parameter int MEM_DEPTH      = 1024,
   parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = 'h8000_0000
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        aw_valid,
   output logic                        aw_ready,
   input  logic [AXI_ADDR_WIDTH-1:0]   aw_addr,
   input  logic [AXI_ID_WIDTH-1:0]     aw_id,
   input  logic [7:0]                  aw_len,
   input  logic [2:0]                  aw_size,
   input  logic [1:0]                  aw_burst,
   input  logic                        w_valid,
   output logic                        w_ready,
   input  logic [AXI_DATA_WIDTH-1:0]   w_data,
   input  logic [AXI_DATA_WIDTH/8-1:0] w_strb,
   input  logic                        w_last,
   output logic                        b_valid,
   input  logic                        b_ready,
   output logic [1:0]                  b_resp,
   output logic [AXI_ID_WIDTH-1:0]     b_id,
   input  logic                        ar_valid,
   output logic                        ar_ready,
   input  logic [AXI_ADDR_WIDTH-1:0]   ar_addr,
   input  logic [AXI_ID_WIDTH-1:0]     ar_id,
   input  logic [7:0]                  ar_len,
   input  logic [2:0]                  ar_size,
   input  logic [1:0]                  ar_burst,
   output logic                        r_valid,
   input  logic                        r_ready,
   output logic [AXI_DATA_WIDTH-1:0]   r_data,
   output logic [1:0]                  r_resp,
   output logic                        r_last,
   output logic [AXI_ID_WIDTH-1:0]     r_id
);

   localparam int STRB_W     = AXI_DATA_WIDTH / 8;
   localparam int BYTE_SHIFT = $clog2(STRB_W);
   localparam int IDX_W      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam logic [AXI_ADDR_WIDTH-1:0] MEM_BYTES  = AXI_ADDR_WIDTH'(MEM_DEPTH) << BYTE_SHIFT;
   localparam logic [AXI_ADDR_WIDTH-1:0] BEAT_BYTES = AXI_ADDR_WIDTH'(STRB_W);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] BURST_INCR  = 2'b01;

   logic [AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH];

   // Offset form avoids overflow when BASE_ADDR sits near the top of the space.
   function automatic logic in_range(input logic [AXI_ADDR_WIDTH-1:0] addr);
      return (addr >= BASE_ADDR) && ((addr - BASE_ADDR) < MEM_BYTES);
   endfunction

   function automatic logic [IDX_W-1:0] word_idx(input logic [AXI_ADDR_WIDTH-1:0] addr);
      return IDX_W'((addr - BASE_ADDR) >> BYTE_SHIFT);
   endfunction

   function automatic logic burst_ok(input logic [1:0] burst);
      return ~burst[1];
   endfunction

   function automatic logic [AXI_ADDR_WIDTH-1:0] next_addr(input logic [AXI_ADDR_WIDTH-1:0] addr,
                                                           input logic [1:0] burst);
      return (burst == BURST_INCR) ? addr + BEAT_BYTES : addr;
   endfunction

   logic unused_size;
   assign unused_size = ^{aw_size, ar_size};

   // ---------------- read engine ----------------
   typedef enum logic {R_IDLE, R_DATA} r_state_t;
   r_state_t r_state, r_state_nxt;

   logic [AXI_ADDR_WIDTH-1:0] r_addr, ld_addr;
   logic [7:0]                r_len, r_beat, r_beat_inc;
   logic [1:0]                r_burst, ld_burst;
   logic                      ar_hs, r_hs, ld_en, ld_ok;

   assign ar_hs = ar_valid & ar_ready;
   assign r_hs  = r_valid & r_ready;

   always_comb begin
      r_state_nxt = r_state;
      r_beat_inc  = r_beat + 8'd1;
      ld_addr     = ar_hs ? ar_addr : next_addr(r_addr, r_burst);
      ld_burst    = ar_hs ? ar_burst : r_burst;
      ld_en       = ar_hs | (r_hs & ~r_last);
      ld_ok       = burst_ok(ld_burst) & in_range(ld_addr);
      case (r_state)
         R_IDLE: if (ar_hs) r_state_nxt = R_DATA;
         R_DATA: if (r_hs && r_last) r_state_nxt = R_IDLE;
         default: r_state_nxt = R_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state  <= R_IDLE;
         ar_ready <= 1'b0;
         r_valid  <= 1'b0;
         r_last   <= 1'b0;
         r_data   <= '0;
         r_resp   <= '0;
         r_id     <= '0;
      end else begin
         r_state  <= r_state_nxt;
         ar_ready <= (r_state_nxt == R_IDLE);
         r_valid  <= (r_state_nxt == R_DATA);
         if (ar_hs) begin
            r_id    <= ar_id;
            r_len   <= ar_len;
            r_burst <= ar_burst;
            r_addr  <= ar_addr;
            r_beat  <= 8'd0;
            r_last  <= (ar_len == 8'd0);
         end else if (r_hs && !r_last) begin
            r_addr  <= ld_addr;
            r_beat  <= r_beat_inc;
            r_last  <= (r_beat_inc == r_len);
         end else if (r_hs) begin
            r_last  <= 1'b0;
         end
         // Nonblocking read of mem: a same-cycle write to this word is not seen.
         if (ld_en) begin
            r_data <= ld_ok ? mem[word_idx(ld_addr)] : '0;
            r_resp <= ld_ok ? RESP_OKAY : RESP_SLVERR;
         end
      end
   end

   // ---------------- write engine ----------------
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   w_state_t w_state, w_state_nxt;

   logic [AXI_ADDR_WIDTH-1:0] w_addr;
   logic [AXI_ID_WIDTH-1:0]   w_id;
   logic [7:0]                w_len, w_beat;
   logic [1:0]                w_burst;
   logic                      w_err, w_err_nxt, w_beat_ok, mem_we;
   logic                      aw_hs, w_hs, b_hs;

   assign aw_hs = aw_valid & aw_ready;
   assign w_hs  = w_valid & w_ready;
   assign b_hs  = b_valid & b_ready;

   always_comb begin
      w_state_nxt = w_state;
      w_beat_ok   = burst_ok(w_burst) & in_range(w_addr);
      // A w_last that disagrees with the beat count poisons the burst.
      w_err_nxt   = w_err | ~w_beat_ok | ((w_beat == w_len) != w_last);
      mem_we      = w_hs & w_beat_ok;
      case (w_state)
         W_IDLE: if (aw_hs) w_state_nxt = W_DATA;
         W_DATA: if (w_hs && w_last) w_state_nxt = W_RESP;
         W_RESP: if (b_hs) w_state_nxt = W_IDLE;
         default: w_state_nxt = W_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         w_state  <= W_IDLE;
         aw_ready <= 1'b0;
         w_ready  <= 1'b0;
         b_valid  <= 1'b0;
         b_resp   <= '0;
         b_id     <= '0;
      end else begin
         w_state  <= w_state_nxt;
         aw_ready <= (w_state_nxt == W_IDLE);
         w_ready  <= (w_state_nxt == W_DATA);
         b_valid  <= (w_state_nxt == W_RESP);
         if (aw_hs) begin
            w_id    <= aw_id;
            w_len   <= aw_len;
            w_burst <= aw_burst;
            w_addr  <= aw_addr;
            w_beat  <= 8'd0;
            w_err   <= 1'b0;
         end else if (w_hs) begin
            w_addr  <= next_addr(w_addr, w_burst);
            w_beat  <= w_beat + 8'd1;
            w_err   <= w_err_nxt;
            if (w_last) begin
               b_resp <= w_err_nxt ? RESP_SLVERR : RESP_OKAY;
               b_id   <= w_id;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (mem_we) begin
         for (int i = 0; i < STRB_W; i++) begin
            if (w_strb[i]) mem[word_idx(w_addr)][8*i +: 8] <= w_data[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_ysyx_22040759_axi_mem_slave.sv
// Directed bench for ysyx_22040759_axi_mem_slave: bursts, strobes, range
// errors, illegal bursts, w_last mismatch, backpressure and mid-burst reset.
module tb_ysyx_22040759_axi_mem_slave;

   logic        clock = 1'b0;
   logic        reset;
   logic        aw_valid, aw_ready;
   logic [63:0] aw_addr;
   logic [3:0]  aw_id;
   logic [7:0]  aw_len;
   logic [2:0]  aw_size;
   logic [1:0]  aw_burst;
   logic        w_valid, w_ready;
   logic [63:0] w_data;
   logic [7:0]  w_strb;
   logic        w_last;
   logic        b_valid, b_ready;
   logic [1:0]  b_resp;
   logic [3:0]  b_id;
   logic        ar_valid, ar_ready;
   logic [63:0] ar_addr;
   logic [3:0]  ar_id;
   logic [7:0]  ar_len;
   logic [2:0]  ar_size;
   logic [1:0]  ar_burst;
   logic        r_valid, r_ready;
   logic [63:0] r_data;
   logic [1:0]  r_resp;
   logic        r_last;
   logic [3:0]  r_id;

   int n_checks = 0;
   int n_fail   = 0;

   logic [63:0] wd [256];
   logic [7:0]  ws [256];
   logic [63:0] rd [256];
   logic [1:0]  rr [256];
   logic        rl [256];
   logic [3:0]  ri [256];

   localparam int LIMIT = 500;

   always #5 clock = ~clock;

   ysyx_22040759_axi_mem_slave dut (
      .clock(clock), .reset(reset),
      .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_id(aw_id),
      .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst),
      .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
      .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp), .b_id(b_id),
      .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_id(ar_id),
      .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
      .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp),
      .r_last(r_last), .r_id(r_id)
   );

   // Write burst: nbeats beats sent, w_last asserted on beat last_at.
   task automatic axi_write(input logic [63:0] addr, input logic [3:0] id, input logic [7:0] len,
                            input logic [1:0] burst, input int nbeats, input int last_at,
                            input bit bp, output logic [1:0] resp, output logic [3:0] bid,
                            output bit to);
      int  cyc;
      bit  got;
      to = 0; resp = 2'bxx; bid = 4'bxxxx;
      aw_valid = 1; aw_addr = addr; aw_id = id; aw_len = len; aw_size = 3'd3; aw_burst = burst;
      cyc = 0;
      while (!aw_ready && cyc < LIMIT) begin @(posedge clock); #1; cyc++; end
      if (cyc >= LIMIT) to = 1;
      @(posedge clock); #1;
      aw_valid = 0;
      for (int b = 0; b < nbeats; b++) begin
         w_valid = 1; w_data = wd[b]; w_strb = ws[b]; w_last = (b == last_at);
         cyc = 0;
         while (!w_ready && cyc < LIMIT) begin @(posedge clock); #1; cyc++; end
         if (cyc >= LIMIT) to = 1;
         @(posedge clock); #1;
      end
      w_valid = 0; w_last = 0;
      got = 0; cyc = 0;
      while (!got && cyc < LIMIT) begin
         if (b_valid) begin
            b_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (b_ready) begin resp = b_resp; bid = b_id; got = 1; end
         end else begin
            b_ready = 0;
         end
         @(posedge clock); #1; cyc++;
      end
      b_ready = 0;
      if (!got) to = 1;
   endtask

   // Read burst; counts cycles from AR handshake to r_valid and stalled-beat changes.
   task automatic axi_read(input logic [63:0] addr, input logic [3:0] id, input logic [7:0] len,
                           input logic [1:0] burst, input bit bp, output int nb,
                           output int first_wait, output int unstable, output bit to);
      int          cyc;
      bit          done, held;
      logic [63:0] hd;
      logic [1:0]  hr;
      logic        hl;
      to = 0; nb = 0; unstable = 0; done = 0; held = 0;
      ar_valid = 1; ar_addr = addr; ar_id = id; ar_len = len; ar_size = 3'd3; ar_burst = burst;
      cyc = 0;
      while (!ar_ready && cyc < LIMIT) begin @(posedge clock); #1; cyc++; end
      if (cyc >= LIMIT) to = 1;
      @(posedge clock); #1;
      ar_valid = 0;
      cyc = 0;
      while (!r_valid && cyc < LIMIT) begin @(posedge clock); #1; cyc++; end
      first_wait = cyc;
      cyc = 0;
      while (!done && cyc < LIMIT) begin
         if (r_valid) begin
            if (held && (r_data !== hd || r_resp !== hr || r_last !== hl)) unstable++;
            r_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (r_ready) begin
               if (nb < 256) begin
                  rd[nb] = r_data; rr[nb] = r_resp; rl[nb] = r_last; ri[nb] = r_id;
               end
               nb++;
               if (r_last) done = 1;
               held = 0;
            end else begin
               held = 1; hd = r_data; hr = r_resp; hl = r_last;
            end
         end
         @(posedge clock); #1; cyc++;
      end
      r_ready = 0;
      if (!done) to = 1;
   endtask

   task automatic test_reset();
      reset = 1;
      repeat (3) begin @(posedge clock); #1; end
      n_checks++;
      if ({aw_ready, w_ready, ar_ready, b_valid, r_valid, r_last} !== 6'b0) begin
         n_fail++; $display("FAIL reset_ctrl: got %b expected 000000", {aw_ready, w_ready, ar_ready, b_valid, r_valid, r_last});
      end
      n_checks++;
      if ({r_data, r_resp, b_resp, r_id, b_id} !== 76'd0) begin
         n_fail++; $display("FAIL reset_data: got %h expected 0", {r_data, r_resp, b_resp, r_id, b_id});
      end
      reset = 0;
      @(posedge clock); #1;
      n_checks++;
      if ({aw_ready, ar_ready, w_ready, b_valid, r_valid} !== 5'b11000) begin
         n_fail++; $display("FAIL reset_release: got %b expected 11000", {aw_ready, ar_ready, w_ready, b_valid, r_valid});
      end
   endtask

   task automatic test_incr_write();
      logic [1:0] resp; logic [3:0] bid; bit to;
      wd[0] = 64'h1111_1111_1111_1111; wd[1] = 64'h2222_2222_2222_2222;
      wd[2] = 64'h3333_3333_3333_3333; wd[3] = 64'h4444_4444_4444_4444;
      for (int i = 0; i < 4; i++) ws[i] = 8'hFF;
      axi_write(64'h8000_0000, 4'h5, 8'd3, 2'b01, 4, 3, 0, resp, bid, to);
      n_checks++;
      if ({to, resp, bid} !== {1'b0, 2'b00, 4'h5}) begin
         n_fail++; $display("FAIL incr_write_b: got to=%0d resp=%b id=%h expected to=0 resp=00 id=5", to, resp, bid);
      end
      n_checks++;
      if (aw_ready !== 1'b1) begin
         n_fail++; $display("FAIL incr_write_awready: got %b expected 1", aw_ready);
      end
   endtask

   task automatic test_incr_read();
      int nb, fw, un; bit to;
      logic [63:0] exp_d [4];
      exp_d[0] = 64'h1111_1111_1111_1111; exp_d[1] = 64'h2222_2222_2222_2222;
      exp_d[2] = 64'h3333_3333_3333_3333; exp_d[3] = 64'h4444_4444_4444_4444;
      axi_read(64'h8000_0000, 4'h9, 8'd3, 2'b01, 0, nb, fw, un, to);
      n_checks++;
      if (to || nb != 4 || fw != 0) begin
         n_fail++; $display("FAIL incr_read_shape: got to=%0d beats=%0d wait=%0d expected 0/4/0", to, nb, fw);
      end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if ({rd[i], rr[i], rl[i], ri[i]} !== {exp_d[i], 2'b00, (i == 3), 4'h9}) begin
            n_fail++; $display("FAIL incr_read_beat%0d: got %h/%b/%b/%h expected %h/00/%b/9",
                               i, rd[i], rr[i], rl[i], ri[i], exp_d[i], (i == 3));
         end
      end
      n_checks++;
      if (ar_ready !== 1'b1) begin
         n_fail++; $display("FAIL incr_read_arready: got %b expected 1", ar_ready);
      end
   endtask

   task automatic test_strobe();
      logic [1:0] resp; logic [3:0] bid; bit to, to2; int nb, fw, un;
      wd[0] = 64'h1122_3344_5566_7788; ws[0] = 8'hFF;
      axi_write(64'h8000_0100, 4'h1, 8'd0, 2'b01, 1, 0, 0, resp, bid, to);
      wd[0] = 64'hAABB_CCDD_EEFF_0011; ws[0] = 8'h0F;
      axi_write(64'h8000_0100, 4'h2, 8'd0, 2'b01, 1, 0, 0, resp, bid, to2);
      axi_read(64'h8000_0100, 4'h3, 8'd0, 2'b01, 0, nb, fw, un, to);
      n_checks++;
      if ({to, to2, resp, rd[0], rr[0]} !== {1'b0, 1'b0, 2'b00, 64'h1122_3344_EEFF_0011, 2'b00}) begin
         n_fail++; $display("FAIL strobe_merge: got %h resp=%b expected 1122334_4EEFF0011 resp=00", rd[0], rr[0]);
      end
   endtask

   task automatic test_out_of_range();
      logic [1:0] resp; logic [3:0] bid; bit to; int nb, fw, un;
      axi_read(64'h7FFF_FFF8, 4'h4, 8'd1, 2'b00, 0, nb, fw, un, to);
      n_checks++;
      if ({to, nb == 2, rd[0], rr[0], rd[1], rr[1]} !== {1'b0, 1'b1, 64'd0, 2'b10, 64'd0, 2'b10}) begin
         n_fail++; $display("FAIL oor_read_fixed: got beats=%0d %h/%b %h/%b expected 2 0/10 0/10", nb, rd[0], rr[0], rd[1], rr[1]);
      end
      axi_read(64'h7FFF_FFF8, 4'h4, 8'd1, 2'b01, 0, nb, fw, un, to);
      n_checks++;
      if ({rd[0], rr[0], rd[1], rr[1]} !== {64'd0, 2'b10, 64'h1111_1111_1111_1111, 2'b00}) begin
         n_fail++; $display("FAIL oor_read_incr: got %h/%b %h/%b expected 0/10 1111111111111111/00", rd[0], rr[0], rd[1], rr[1]);
      end
      wd[0] = 64'h5A5A_5A5A_0000_1FF8; ws[0] = 8'hFF;
      axi_write(64'h8000_1FF8, 4'h6, 8'd0, 2'b01, 1, 0, 0, resp, bid, to);
      n_checks++;
      if ({to, resp} !== 3'b000) begin
         n_fail++; $display("FAIL top_word_write: got to=%0d resp=%b expected 0/00", to, resp);
      end
      wd[0] = 64'hDEAD_BEEF_DEAD_BEEF;
      axi_write(64'h8000_2000, 4'h7, 8'd0, 2'b01, 1, 0, 0, resp, bid, to);
      n_checks++;
      if ({to, resp, bid} !== {1'b0, 2'b10, 4'h7}) begin
         n_fail++; $display("FAIL oor_write_b: got to=%0d resp=%b id=%h expected 0/10/7", to, resp, bid);
      end
      axi_read(64'h8000_1FF8, 4'h8, 8'd0, 2'b01, 0, nb, fw, un, to);
      n_checks++;
      if (rd[0] !== 64'h5A5A_5A5A_0000_1FF8) begin
         n_fail++; $display("FAIL top_word_read: got %h expected 5a5a5a5a00001ff8", rd[0]);
      end
      axi_read(64'h8000_0000, 4'h8, 8'd0, 2'b01, 0, nb, fw, un, to);
      n_checks++;
      if (rd[0] !== 64'h1111_1111_1111_1111) begin
         n_fail++; $display("FAIL oor_write_alias: got %h expected 1111111111111111", rd[0]);
      end
   endtask

   task automatic test_concurrent();
      logic [1:0] resp; logic [3:0] bid; bit to_w, to_r, to; int nb, fw, un;
      for (int i = 0; i < 16; i++) begin wd[i] = 64'hA0A0_0000_0000_0000 | 64'(i); ws[i] = 8'hFF; end
      axi_write(64'h8000_0400, 4'h1, 8'd15, 2'b01, 16, 15, 0, resp, bid, to);
      for (int i = 0; i < 16; i++) wd[i] = 64'hB0B0_0000_0000_0000 | 64'(i);
      fork
         axi_read(64'h8000_0400, 4'hA, 8'd15, 2'b01, 1, nb, fw, un, to_r);
         axi_write(64'h8000_0800, 4'hB, 8'd15, 2'b01, 16, 15, 1, resp, bid, to_w);
      join
      n_checks++;
      if ({to_r, to_w, resp, bid} !== {1'b0, 1'b0, 2'b00, 4'hB}) begin
         n_fail++; $display("FAIL conc_write_b: got to=%0d/%0d resp=%b id=%h expected 0/0/00/b", to_r, to_w, resp, bid);
      end
      n_checks++;
      if (nb != 16 || un != 0) begin
         n_fail++; $display("FAIL conc_read_stall: got beats=%0d unstable=%0d expected 16/0", nb, un);
      end
      for (int i = 0; i < 16; i++) begin
         n_checks++;
         if ({rd[i], rr[i], rl[i]} !== {64'hA0A0_0000_0000_0000 | 64'(i), 2'b00, (i == 15)}) begin
            n_fail++; $display("FAIL conc_read_beat%0d: got %h/%b/%b expected a0a0..%0h/00/%b", i, rd[i], rr[i], rl[i], i, (i == 15));
         end
      end
      axi_read(64'h8000_0800, 4'hC, 8'd15, 2'b01, 0, nb, fw, un, to);
      for (int i = 0; i < 16; i++) begin
         n_checks++;
         if (rd[i] !== (64'hB0B0_0000_0000_0000 | 64'(i))) begin
            n_fail++; $display("FAIL conc_write_data%0d: got %h expected b0b0..%0h", i, rd[i], i);
         end
      end
   endtask

   task automatic test_wrap();
      logic [1:0] resp; logic [3:0] bid; bit to; int nb, fw, un;
      for (int i = 0; i < 4; i++) begin wd[i] = 64'hFFFF_0000_0000_0000 | 64'(i); ws[i] = 8'hFF; end
      axi_write(64'h8000_0000, 4'h2, 8'd3, 2'b10, 4, 3, 0, resp, bid, to);
      n_checks++;
      if ({to, resp} !== 3'b010) begin
         n_fail++; $display("FAIL wrap_write_b: got to=%0d resp=%b expected 0/10", to, resp);
      end
      axi_read(64'h8000_0000, 4'h2, 8'd3, 2'b10, 0, nb, fw, un, to);
      n_checks++;
      if (to || nb != 4) begin
         n_fail++; $display("FAIL wrap_read_beats: got to=%0d beats=%0d expected 0/4", to, nb);
      end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if ({rd[i], rr[i], rl[i]} !== {64'd0, 2'b10, (i == 3)}) begin
            n_fail++; $display("FAIL wrap_read_beat%0d: got %h/%b/%b expected 0/10/%b", i, rd[i], rr[i], rl[i], (i == 3));
         end
      end
      axi_read(64'h8000_0000, 4'h2, 8'd0, 2'b01, 0, nb, fw, un, to);
      n_checks++;
      if (rd[0] !== 64'h1111_1111_1111_1111) begin
         n_fail++; $display("FAIL wrap_no_write: got %h expected 1111111111111111", rd[0]);
      end
   endtask

   task automatic test_early_last();
      logic [1:0] resp; logic [3:0] bid; bit to; int nb, fw, un;
      wd[0] = 64'hC0; wd[1] = 64'hC1; ws[0] = 8'hFF; ws[1] = 8'hFF;
      axi_write(64'h8000_0600, 4'hD, 8'd3, 2'b01, 2, 1, 0, resp, bid, to);
      n_checks++;
      if ({to, resp, bid, aw_ready} !== {1'b0, 2'b10, 4'hD, 1'b1}) begin
         n_fail++; $display("FAIL early_last_b: got to=%0d resp=%b id=%h awr=%b expected 0/10/d/1", to, resp, bid, aw_ready);
      end
      axi_read(64'h8000_0600, 4'hE, 8'd1, 2'b01, 0, nb, fw, un, to);
      n_checks++;
      if ({rd[0], rd[1]} !== {64'hC0, 64'hC1}) begin
         n_fail++; $display("FAIL early_last_data: got %h %h expected c0 c1", rd[0], rd[1]);
      end
      wd[0] = 64'hC2;
      axi_write(64'h8000_0610, 4'h3, 8'd0, 2'b01, 1, 0, 0, resp, bid, to);
      n_checks++;
      if ({to, resp} !== 3'b000) begin
         n_fail++; $display("FAIL early_last_recover: got to=%0d resp=%b expected 0/00", to, resp);
      end
   endtask

   task automatic test_reset_mid_burst();
      int nb, fw, un; bit to;
      ar_valid = 1; ar_addr = 64'h8000_0400; ar_id = 4'h3; ar_len = 8'd7; ar_burst = 2'b01;
      r_ready = 1;
      @(posedge clock); #1;
      ar_valid = 0;
      repeat (2) begin @(posedge clock); #1; end
      n_checks++;
      if ({r_valid, r_data} !== {1'b1, 64'hA0A0_0000_0000_0002}) begin
         n_fail++; $display("FAIL midrst_beat2: got vld=%b %h expected 1 a0a0000000000002", r_valid, r_data);
      end
      r_ready = 0; reset = 1;
      @(posedge clock); #1;
      n_checks++;
      if ({r_valid, b_valid, r_last, ar_ready, aw_ready, w_ready} !== 6'b0) begin
         n_fail++; $display("FAIL midrst_valids: got %b expected 000000", {r_valid, b_valid, r_last, ar_ready, aw_ready, w_ready});
      end
      reset = 0;
      @(posedge clock); #1;
      axi_read(64'h8000_0400, 4'h5, 8'd1, 2'b01, 0, nb, fw, un, to);
      n_checks++;
      if ({to, nb == 2, rd[0], rd[1], rl[1], ri[1]} !== {1'b0, 1'b1, 64'hA0A0_0000_0000_0000, 64'hA0A0_0000_0000_0001, 1'b1, 4'h5}) begin
         n_fail++; $display("FAIL midrst_fresh_read: got to=%0d beats=%0d %h %h expected 0 2 a0a0..00 a0a0..01", to, nb, rd[0], rd[1]);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1;
      aw_valid = 0; aw_addr = '0; aw_id = '0; aw_len = '0; aw_size = 3'd3; aw_burst = 2'b01;
      w_valid = 0; w_data = '0; w_strb = '0; w_last = 0; b_ready = 0;
      ar_valid = 0; ar_addr = '0; ar_id = '0; ar_len = '0; ar_size = 3'd3; ar_burst = 2'b01;
      r_ready = 0;
      test_reset();
      test_incr_write();
      test_incr_read();
      test_strobe();
      test_out_of_range();
      test_concurrent();
      test_wrap();
      test_early_last();
      test_reset_mid_burst();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
